// File: rtl/gemm_tile_controller_pkg.sv
// Shared state encodings and core-matched timing defaults for the GEMM tile controller.
// The debug readout uses these same encodings.
package gemm_tile_controller_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_W  = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // These must track the core pipeline so load/drain windows line up with it.
  localparam int DEFAULT_LOAD_CYCLES = 24;
  localparam int DEFAULT_LATENCY     = 28;

  // Width of the shared load/drain phase counter, which counts 0..max-1.
  function automatic int phase_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/gemm_tile_controller_tile_index_counter.sv
// Nested n/k tile index counter: k is the inner index, n advances when k wraps.
// Provides first/last flags so address generators can reuse the same sequencing.
module tile_index_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         adv_i,
  input  logic [W-1:0] n_max_i,
  input  logic [W-1:0] k_max_i,
  output logic [W-1:0] n_idx_o,
  output logic [W-1:0] k_idx_o,
  output logic         k_first_o,
  output logic         k_last_o,
  output logic         all_last_o
);

  logic [W-1:0] n_q, n_d;
  logic [W-1:0] k_q, k_d;

  assign k_first_o  = (k_q == '0);
  assign k_last_o   = (k_q == k_max_i);
  assign all_last_o = k_last_o && (n_q == n_max_i);

  always_comb begin
    n_d = n_q;
    k_d = k_q;
    if (clr_i) begin
      n_d = '0;
      k_d = '0;
    end else if (adv_i) begin
      if (k_last_o) begin
        k_d = '0;
        n_d = (n_q == n_max_i) ? '0 : n_q + W'(1);
      end else begin
        k_d = k_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
      k_q <= '0;
    end else begin
      n_q <= n_d;
      k_q <= k_d;
    end
  end

  assign n_idx_o = n_q;
  assign k_idx_o = k_q;

endmodule

// File: rtl/gemm_tile_controller.sv
// Tiled GEMM global controller: one LOAD_W/COMPUTE/DRAIN pass per (n,k) tile pair.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module gemm_tile_controller
  import gemm_tile_controller_pkg::*;
#(
  parameter int LOAD_CYCLES = DEFAULT_LOAD_CYCLES,
  parameter int LATENCY     = DEFAULT_LATENCY,
  parameter int SEQ_W       = 16,
  parameter int TILE_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ap_start,
  input  logic              ap_abort,
  input  logic [SEQ_W-1:0]  cfg_seq_len,
  input  logic [TILE_W-1:0] cfg_n_tiles,
  input  logic [TILE_W-1:0] cfg_k_tiles,
  input  logic              in_stall,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_err,
  output logic [2:0]        current_state_dbg,
  output logic              ctrl_weight_load_en,
  output logic              ctrl_input_stream_en,
  output logic              ctrl_drain_en,
  output logic              ctrl_acc_first,
  output logic              ctrl_acc_last,
  output logic [TILE_W-1:0] tile_n_idx,
  output logic [TILE_W-1:0] tile_k_idx,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_stall_cycles
);

  localparam int PH_W = phase_cnt_w(LOAD_CYCLES, LATENCY);

  logic [2:0]        state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [SEQ_W-1:0]  seq_q, seq_d, seq_max_q, seq_max_d;
  logic [TILE_W-1:0] n_max_q, n_max_d, k_max_q, k_max_d;
  logic              err_q, err_d;
  logic              start_ok, cfg_zero, tile_clr, tile_adv;
  logic              k_first, k_last, all_last, streaming;

  assign start_ok  = (state_q == ST_IDLE) && ap_start;
  assign cfg_zero  = (cfg_seq_len == '0) || (cfg_n_tiles == '0) || (cfg_k_tiles == '0);
  assign streaming = (state_q == ST_COMPUTE) && !in_stall;

  tile_index_counter #(.W(TILE_W)) u_tile_idx (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (tile_clr),
    .adv_i      (tile_adv),
    .n_max_i    (n_max_q),
    .k_max_i    (k_max_q),
    .n_idx_o    (tile_n_idx),
    .k_idx_o    (tile_k_idx),
    .k_first_o  (k_first),
    .k_last_o   (k_last),
    .all_last_o (all_last)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    seq_d     = seq_q;
    seq_max_d = seq_max_q;
    n_max_d   = n_max_q;
    k_max_d   = k_max_q;
    err_d     = err_q;
    tile_clr  = 1'b0;
    tile_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          // Latched maxima of a zero config wrap, but that job never leaves DONE.
          seq_max_d = cfg_seq_len - SEQ_W'(1);
          n_max_d   = cfg_n_tiles - TILE_W'(1);
          k_max_d   = cfg_k_tiles - TILE_W'(1);
          err_d     = cfg_zero;
          tile_clr  = 1'b1;
          ph_d      = '0;
          state_d   = cfg_zero ? ST_DONE : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (ph_q == PH_W'(LOAD_CYCLES - 1)) begin
          ph_d    = '0;
          seq_d   = '0;
          state_d = ST_COMPUTE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_COMPUTE: begin
        if (!in_stall) begin
          if (seq_q == seq_max_q) begin
            ph_d    = '0;
            state_d = ST_DRAIN;
          end else begin
            seq_d = seq_q + SEQ_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (ph_q == PH_W'(LATENCY - 1)) begin
          ph_d = '0;
          if (all_last) begin
            state_d = ST_DONE;
          end else begin
            tile_adv = 1'b1;
            state_d  = ST_LOAD_W;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (ap_abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      ph_d     = '0;
      tile_adv = 1'b0;
    end
  end

  // Strobes decode the current state, so they trail the state register by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= ST_IDLE;
      ph_q                 <= '0;
      seq_q                <= '0;
      seq_max_q            <= '0;
      n_max_q              <= '0;
      k_max_q              <= '0;
      err_q                <= 1'b0;
      ap_done              <= 1'b0;
      ap_idle              <= 1'b1;
      ctrl_weight_load_en  <= 1'b0;
      ctrl_input_stream_en <= 1'b0;
      ctrl_drain_en        <= 1'b0;
      ctrl_acc_first       <= 1'b0;
      ctrl_acc_last        <= 1'b0;
    end else begin
      state_q              <= state_d;
      ph_q                 <= ph_d;
      seq_q                <= seq_d;
      seq_max_q            <= seq_max_d;
      n_max_q              <= n_max_d;
      k_max_q              <= k_max_d;
      err_q                <= err_d;
      ap_done              <= (state_q == ST_DONE);
      ap_idle              <= (state_q == ST_IDLE);
      ctrl_weight_load_en  <= (state_q == ST_LOAD_W);
      ctrl_input_stream_en <= streaming;
      ctrl_drain_en        <= (state_q == ST_DRAIN);
      ctrl_acc_first       <= streaming && k_first;
      ctrl_acc_last        <= streaming && k_last;
    end
  end

  assign ap_err            = err_q;
  assign current_state_dbg = state_q;

`ifdef PERF_CNT_EN
  logic [1:0] perf_inc;
  assign perf_inc = {(state_q == ST_COMPUTE) && in_stall, state_q != ST_IDLE};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (start_ok) begin
        cnt_q <= '0;
      end else if (perf_inc[gi] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign perf_busy_cycles  = g_perf[0].cnt_q;
  assign perf_stall_cycles = g_perf[1].cnt_q;
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_gemm_tile_controller.sv
// Directed bench for gemm_tile_controller with default LOAD_CYCLES=24, LATENCY=28.
// Timing is measured in clock edges relative to the edge that samples ap_start.
module tb_gemm_tile_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ap_start, ap_abort, in_stall;
  logic [15:0] cfg_seq_len;
  logic [7:0]  cfg_n_tiles, cfg_k_tiles;
  logic        ap_done, ap_idle, ap_err;
  logic [2:0]  current_state_dbg;
  logic        ctrl_weight_load_en, ctrl_input_stream_en, ctrl_drain_en;
  logic        ctrl_acc_first, ctrl_acc_last;
  logic [7:0]  tile_n_idx, tile_k_idx;
  logic [31:0] perf_busy_cycles, perf_stall_cycles;

  gemm_tile_controller dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ap_start             (ap_start),
    .ap_abort             (ap_abort),
    .cfg_seq_len          (cfg_seq_len),
    .cfg_n_tiles          (cfg_n_tiles),
    .cfg_k_tiles          (cfg_k_tiles),
    .in_stall             (in_stall),
    .ap_done              (ap_done),
    .ap_idle              (ap_idle),
    .ap_err               (ap_err),
    .current_state_dbg    (current_state_dbg),
    .ctrl_weight_load_en  (ctrl_weight_load_en),
    .ctrl_input_stream_en (ctrl_input_stream_en),
    .ctrl_drain_en        (ctrl_drain_en),
    .ctrl_acc_first       (ctrl_acc_first),
    .ctrl_acc_last        (ctrl_acc_last),
    .tile_n_idx           (tile_n_idx),
    .tile_k_idx           (tile_k_idx),
    .perf_busy_cycles     (perf_busy_cycles),
    .perf_stall_cycles    (perf_stall_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int start_cyc, done_rel, n_load, n_stream, n_drain, n_first, n_last, n_done, n_stray;
  logic err0, idle_a1, idle_a2, drain_a1, drain_a2;
  logic [15:0] tiles[$];
  logic [15:0] exp_tiles [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int n, input int k, input int s);
    @(negedge clk);
    cfg_n_tiles = 8'(n);
    cfg_k_tiles = 8'(k);
    cfg_seq_len = 16'(s);
    ap_start    = 1'b1;
    @(posedge clk);
    #1;
    start_cyc   = cyc;
    ap_start    = 1'b0;
    // Busy-time config changes must not affect the running job.
    cfg_seq_len = 16'(s + 3);
    cfg_n_tiles = 8'(n + 1);
  endtask

  task automatic run_job(input int n, input int k, input int s, input int st_from,
                         input int st_len, input int ab_at, input int bound);
    int  rel;
    logic prev_load;
    done_rel = -1; n_load = 0; n_stream = 0; n_drain = 0; n_first = 0; n_last = 0;
    n_done = 0; n_stray = 0; prev_load = 1'b0;
    idle_a1 = 1'bx; idle_a2 = 1'bx; drain_a1 = 1'bx; drain_a2 = 1'bx; err0 = 1'bx;
    tiles.delete();
    start_job(n, k, s);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      rel = cyc - start_cyc;
      if (rel == 0) err0 = ap_err;
      n_load   += int'(ctrl_weight_load_en);
      n_stream += int'(ctrl_input_stream_en);
      n_drain  += int'(ctrl_drain_en);
      n_first  += int'(ctrl_acc_first);
      n_last   += int'(ctrl_acc_last);
      n_done   += int'(ap_done);
      if ((ctrl_acc_first || ctrl_acc_last) && !ctrl_input_stream_en) n_stray++;
      if (ctrl_weight_load_en && !prev_load) tiles.push_back({tile_n_idx, tile_k_idx});
      prev_load = ctrl_weight_load_en;
      if (ap_done && done_rel < 0) done_rel = rel;
      if (rel == ab_at + 1) begin idle_a1 = ap_idle; drain_a1 = ctrl_drain_en; end
      if (rel == ab_at + 2) begin idle_a2 = ap_idle; drain_a2 = ctrl_drain_en; end
      in_stall = (rel >= st_from) && (rel < st_from + st_len);
      ap_abort = (rel == ab_at);
      if (done_rel >= 0 && rel >= done_rel + 3) break;
    end
    in_stall = 1'b0;
    ap_abort = 1'b0;
    $display("[TB] job N=%0d K=%0d seq=%0d: done_rel=%0d load=%0d stream=%0d drain=%0d",
             n, k, s, done_rel, n_load, n_stream, n_drain);
  endtask

  initial begin
    rst_n = 1'b0; ap_start = 1'b0; ap_abort = 1'b0; in_stall = 1'b0;
    cfg_seq_len = '0; cfg_n_tiles = '0; cfg_k_tiles = '0;
    exp_tiles = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101, 16'h0102};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_outs", {ap_done, ap_err, current_state_dbg, ctrl_weight_load_en,
                     ctrl_input_stream_en, ctrl_drain_en, tile_n_idx, tile_k_idx}, 0);

    // 1: single tile, no stalls
    run_job(1, 1, 4, -10, 0, -10, 100);
    chk("t1_done_rel", done_rel, 57);
    chk("t1_load", n_load, 24);
    chk("t1_stream", n_stream, 4);
    chk("t1_drain", n_drain, 28);
    chk("t1_first", n_first, 4);
    chk("t1_last", n_last, 4);
    chk("t1_ndone", n_done, 1);
    chk("t1_tiles", tiles.size(), 1);
`ifdef PERF_CNT_EN
    chk("t1_busy", perf_busy_cycles, 57);
`endif

    // 2: 2x3 tiles
    run_job(2, 3, 5, -10, 0, -10, 400);
    chk("t2_done_rel", done_rel, 343);
    chk("t2_load", n_load, 144);
    chk("t2_stream", n_stream, 30);
    chk("t2_drain", n_drain, 168);
    chk("t2_first", n_first, 10);
    chk("t2_last", n_last, 10);
    chk("t2_stray", n_stray, 0);
    chk("t2_ntiles", tiles.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("t2_tile", (tiles.size() > i) ? tiles[i] : 16'hdead, exp_tiles[i]);

    // 3: three stall cycles sampled at edges 28..30 (inside COMPUTE)
    run_job(1, 1, 8, 27, 3, -10, 100);
    chk("t3_done_rel", done_rel, 64);
    chk("t3_stream", n_stream, 8);
`ifdef PERF_CNT_EN
    chk("t3_stall", perf_stall_cycles, 3);
    chk("t3_busy", perf_busy_cycles, 64);
`else
    chk("t3_perf_off", {perf_stall_cycles, perf_busy_cycles} == 64'd0, 1);
`endif

    // 4: zero sequence length is a config error
    run_job(2, 2, 0, -10, 0, -10, 20);
    chk("t4_err0", err0, 1);
    chk("t4_done_rel", done_rel, 1);
    chk("t4_strobes", n_load + n_stream + n_drain, 0);
    chk("t4_err_sticky", ap_err, 1);

    // 5: abort in pass-2 drain (edges 84..111 are DRAIN), then a clean job
    run_job(1, 2, 4, -10, 0, 90, 100);
    chk("t5_err_clr", err0, 0);
    chk("t5_ndone", n_done, 0);
    chk("t5_idle_a1", idle_a1, 0);
    chk("t5_idle_a2", idle_a2, 1);
    chk("t5_drain_a1", drain_a1, 1);
    chk("t5_drain_a2", drain_a2, 0);
    chk("t5_stream", n_stream, 8);
    chk("t5_err_kept", ap_err, 0);
    run_job(1, 1, 4, -10, 0, -10, 100);
    chk("t5_rerun_done", done_rel, 57);
    chk("t5_rerun_stream", n_stream, 4);

    // 6: asynchronous reset in the middle of COMPUTE
    start_job(1, 1, 8);
    repeat (27) @(negedge clk);
    chk("t6_pre_stream", ctrl_input_stream_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_idle", ap_idle, 1);
    chk("t6_outs", {ap_done, ap_err, current_state_dbg, ctrl_weight_load_en,
                    ctrl_input_stream_en, ctrl_drain_en, ctrl_acc_first, ctrl_acc_last,
                    tile_n_idx, tile_k_idx}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(1, 1, 4, -10, 0, -10, 100);
    chk("t6_after_done", done_rel, 57);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gemm_tile_controller.md
Name: gemm_tile_controller

Overview:
- Parametrised successor to the single-pass load/compute/drain global controller.
- Sequences a tiled GEMM: cfg_n_tiles output-column tiles × cfg_k_tiles reduction tiles.
- Runs one LOAD_W → COMPUTE → DRAIN pass per (n,k) tile pair, then pulses ap_done once.
- Adds per-tile index and accumulator control, input-stall backpressure, abort, and config error detection; drives weight buffer, input buffer, accumulator and address generators.

Parameters:
LOAD_CYCLES, 24, cycles of ctrl_weight_load_en per tile pass (≥1)
LATENCY, 28, drain cycles per tile pass; must match core pipeline depth (≥1)
SEQ_W, 16, width of cfg_seq_len and the sequence counter
TILE_W, 8, width of the tile counts and tile indices

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ap_start  in  1  start request, sampled only in IDLE
ap_abort  in  1  abort, any non-IDLE state
cfg_seq_len  in  SEQ_W  input vectors per tile pass (M)
cfg_n_tiles  in  TILE_W  output tile count
cfg_k_tiles  in  TILE_W  reduction tile count
in_stall  in  1  input buffer not ready; freezes COMPUTE
ap_done  out  1  one-cycle completion pulse
ap_idle  out  1  controller idle
ap_err  out  1  sticky config error; cleared by next accepted ap_start
current_state_dbg  out  3  FSM state
ctrl_weight_load_en  out  1  weight load strobe
ctrl_input_stream_en  out  1  one input vector consumed
ctrl_drain_en  out  1  drain window
ctrl_acc_first  out  1  accumulator overwrite (k==0) during streaming
ctrl_acc_last  out  1  accumulator writeback (k==K-1) during streaming
tile_n_idx  out  TILE_W  current n tile
tile_k_idx  out  TILE_W  current k tile
perf_busy_cycles  out  32  optional perf counter
perf_stall_cycles  out  32  optional perf counter

Behaviour:
- States: IDLE=0, LOAD_W=1, COMPUTE=2, DRAIN=3, DONE=4.
- Reset: state IDLE; ap_idle=1; all other outputs, counters and tile indices 0.
- All outputs are registered and decoded from the current state, so they lag state by one cycle.
- IDLE:
  - ap_start=1 latches cfg_*, clears ap_err and tile indices.
  - If any latched cfg is 0: set ap_err, go to DONE (no LOAD).
  - Otherwise go to LOAD_W.
- LOAD_W: weight_load_en=1 for exactly LOAD_CYCLES cycles, then COMPUTE.
- COMPUTE:
  - When in_stall=0: the sequence counter increments and stream_en=1 next cycle.
  - When in_stall=1: the counter holds and stream_en=0.
  - Exactly cfg_seq_len stream_en pulses per pass.
  - After the final unstalled cycle, go to DRAIN.
  - acc_first and acc_last assert exactly coincident with stream_en, per tile_k_idx.
  - When K=1, acc_first and acc_last are both set.
- DRAIN:
  - drain_en=1 for LATENCY cycles.
  - Then advance k; at k=K-1, wrap k to 0 and advance n.
  - Go to LOAD_W, or to DONE after the last (n,k) pair.
  - Tile indices update on the DRAIN→LOAD_W edge.
- DONE: ap_done=1 for one cycle, then IDLE.
- Abort:
  - ap_abort in a non-IDLE state goes to IDLE next edge.
  - No ap_done; ap_err unchanged.
  - Strobes clear with the normal one-cycle lag.
  - Abort has priority over every transition.
- ap_start while busy is ignored. Config changes while busy are ignored.
- Timing, no stalls: with T = N·K·(LOAD_CYCLES+seq+LATENCY), ap_done is high in the cycle following edge T+1, counted from the edge that sampled ap_start. Each stall cycle adds 1.
- Counter rollover: compare against latched cfg−1 only after the zero check, so there is no rollover.

Optional Feature:
PERF_CNT_EN:
- Defined:
  - perf_busy_cycles counts cycles with state≠IDLE.
  - perf_stall_cycles counts COMPUTE cycles with in_stall=1.
  - Both clear on an accepted ap_start and saturate at 2^32−1.
- Undefined: both ports are driven constant 0 and no counter flops are inferred.

Decomposition:
- params.vh holds:
  - state encodings (shared with the debug readout)
  - default LOAD_CYCLES and LATENCY, so they stay consistent with the core
- One sub-module, tile_index_counter: nested n/k counter with wrap and last-tile flags, reusable by address generators.

Test Plan:
1. N=1, K=1, seq=4, no stall → load_en high 24 cycles, stream_en 4, drain_en 28; ap_done at edge 57 after start; acc_first=acc_last=1 during streaming.
2. N=2, K=3, seq=5 → 6 passes; tile (n,k) sequence (0,0),(0,1),(0,2),(1,0)…(1,2); acc_first only at k=0, acc_last only at k=2; ap_done after 6·57+1 edges.
3. seq=8 with in_stall high for 3 cycles mid-COMPUTE → still 8 stream_en pulses; ap_done delayed by 3 cycles; perf_stall_cycles=3 (PERF_CNT_EN).
4. cfg_seq_len=0 → ap_err=1, ap_done pulse 2 cycles after start, no load/stream/drain strobes; next valid start clears ap_err.
5. ap_abort during DRAIN of pass 2 → IDLE next edge, no ap_done, ap_idle=1; subsequent start runs a full job correctly.
6. rst_n asserted mid-COMPUTE → all outputs 0 and ap_idle=1 immediately, without waiting for a clock edge.
